// File: rtl/audio_nios_sd_socket_ctrl.sv
// rtl/audio_nios_sd_socket_ctrl.sv - SD socket debounce, power sequencing and Avalon status block
module audio_nios_sd_socket_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int POWER_UP_CYCLES = 12500,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        cd_n_in,
    input  logic        wp_n_in,
    output logic        sd_pwr_en,
    output logic        card_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_POWER_UP   = 2'd1,
        ST_READY      = 2'd2,
        ST_FORCED_OFF = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWER_UP_CYCLES - 1);

    logic [1:0]       cd_sync, wp_sync;
    logic [1:0]       raw, stable, toggle;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [CNT_W-1:0] pwr_cnt;
    logic [1:0]       irq_mask, edge_capture, w1c;
    logic             force_off, wr_en;
    state_t           state, next_state;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:2];
    assign wr_en        = chipselect & ~write_n;

    // Synchronisers idle at 1 so reset looks like an empty, unprotected socket.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cd_sync <= 2'b11;
            wp_sync <= 2'b11;
        end else begin
            cd_sync <= {cd_sync[0], cd_n_in};
            wp_sync <= {wp_sync[0], wp_n_in};
        end
    end

    // bit0 = present, bit1 = wprot; both pins are active low.
    assign raw = ~{wp_sync[1], cd_sync[1]};

    always_comb begin
        toggle = '0;
        for (int i = 0; i < 2; i++) begin
            toggle[i] = (raw[i] != stable[i]) && (deb_cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (toggle[i]) begin
                    stable[i]  <= ~stable[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w1c = (wr_en && address == 2'd2) ? writedata[1:0] : 2'b00;

    // A new edge event outranks a simultaneous software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            force_off    <= 1'b0;
        end else begin
            edge_capture <= toggle | (edge_capture & ~w1c);
            if (wr_en && address == 2'd1) irq_mask  <= writedata[1:0];
            if (wr_en && address == 2'd3) force_off <= writedata[0];
        end
    end

    assign irq = |(edge_capture & irq_mask);

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: begin
                if (stable[0] && !force_off) next_state = ST_POWER_UP;
            end
            ST_POWER_UP: begin
                if (!stable[0])              next_state = ST_EMPTY;
                else if (force_off)          next_state = ST_FORCED_OFF;
                else if (pwr_cnt == PWR_LAST) next_state = ST_READY;
            end
            ST_READY: begin
                if (!stable[0])     next_state = ST_EMPTY;
                else if (force_off) next_state = ST_FORCED_OFF;
            end
            default: begin
                if (!stable[0])      next_state = ST_EMPTY;
                else if (!force_off) next_state = ST_POWER_UP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_EMPTY;
            pwr_cnt    <= '0;
            sd_pwr_en  <= 1'b0;
            card_ready <= 1'b0;
        end else begin
            state      <= next_state;
            sd_pwr_en  <= (next_state == ST_POWER_UP) || (next_state == ST_READY);
            card_ready <= (next_state == ST_READY);
            if (next_state == ST_POWER_UP && state != ST_POWER_UP) pwr_cnt <= '0;
            else if (state == ST_POWER_UP)                          pwr_cnt <= pwr_cnt + 1'b1;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = {27'd0, state, card_ready, stable[1], stable[0]};
            2'd1:    rd_mux = {30'd0, irq_mask};
            2'd2:    rd_mux = {30'd0, edge_capture};
            default: rd_mux = {31'd0, force_off};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule
